// File: rtl/goldschmidt_seq.sv
// rtl/goldschmidt_seq.sv - sequencer for the shared-multiplier Goldschmidt divide/sqrt datapath
// Steps LOAD, N/D(/D)/K refinement iterations, the Q*D product and the rounding REM cycle.
module goldschmidt_seq #(
  parameter int N_ITER  = 3,
  parameter int MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       enableN,
  output logic       enableD,
  output logic       enableK,
  output logic       enableQD,
  output logic       rem,
  output logic [1:0] mul_sel,
  output logic [3:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MULN,
    S_MULD,
    S_MULD2,
    S_CALCK,
    S_QD,
    S_REM
  } state_t;

  localparam logic [1:0] LAT_M1    = 2'(MUL_LAT - 1);
  localparam logic       ONE_CYC   = (MUL_LAT == 1);
  localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

  localparam logic [1:0] SEL_NK   = 2'b00;
  localparam logic [1:0] SEL_DK   = 2'b01;
  localparam logic [1:0] SEL_QD   = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  state_t     r_state;
  logic       r_sqrt;
  logic [1:0] r_cnt;

  logic w_win_end;
  logic w_win_penult;

  assign w_win_end    = (r_cnt == 2'd0);
  assign w_win_penult = (r_cnt == 2'd1);

  // Outputs are registered alongside the state: each transition sets the values for the cycle it enters.
  // A multiplier window lasts MUL_LAT cycles; its enable fires only in the cycle where r_cnt is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_sqrt   <= 1'b0;
      r_cnt    <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      enableN  <= 1'b0;
      enableD  <= 1'b0;
      enableK  <= 1'b0;
      enableQD <= 1'b0;
      rem      <= 1'b0;
      mul_sel  <= SEL_IDLE;
      iter     <= 4'd0;
    end else begin
      enableN  <= 1'b0;
      enableD  <= 1'b0;
      enableK  <= 1'b0;
      enableQD <= 1'b0;
      rem      <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !op[1]) begin
            r_sqrt  <= op[0];
            r_state <= S_LOAD;
            busy    <= 1'b1;
            enableN <= 1'b1;
            enableD <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_MULN;
          r_cnt   <= LAT_M1;
          mul_sel <= SEL_NK;
          enableN <= ONE_CYC;
          iter    <= 4'd0;
        end
        S_MULN: begin
          if (!w_win_end) begin
            r_cnt   <= r_cnt - 2'd1;
            enableN <= w_win_penult;
          end else begin
            r_state <= S_MULD;
            r_cnt   <= LAT_M1;
            mul_sel <= SEL_DK;
            enableD <= ONE_CYC;
          end
        end
        S_MULD: begin
          if (!w_win_end) begin
            r_cnt   <= r_cnt - 2'd1;
            enableD <= w_win_penult;
          end else if (r_sqrt) begin
            r_state <= S_MULD2;
            r_cnt   <= LAT_M1;
            mul_sel <= SEL_DK;
            enableD <= ONE_CYC;
          end else begin
            r_state <= S_CALCK;
            mul_sel <= SEL_IDLE;
            enableK <= 1'b1;
          end
        end
        S_MULD2: begin
          if (!w_win_end) begin
            r_cnt   <= r_cnt - 2'd1;
            enableD <= w_win_penult;
          end else begin
            r_state <= S_CALCK;
            mul_sel <= SEL_IDLE;
            enableK <= 1'b1;
          end
        end
        S_CALCK: begin
          r_cnt <= LAT_M1;
          if (iter == LAST_ITER) begin
            r_state  <= S_QD;
            iter     <= 4'd0;
            mul_sel  <= SEL_QD;
            enableQD <= ONE_CYC;
          end else begin
            r_state <= S_MULN;
            iter    <= iter + 4'd1;
            mul_sel <= SEL_NK;
            enableN <= ONE_CYC;
          end
        end
        S_QD: begin
          if (!w_win_end) begin
            r_cnt    <= r_cnt - 2'd1;
            enableQD <= w_win_penult;
          end else begin
            r_state <= S_REM;
            mul_sel <= SEL_IDLE;
            rem     <= 1'b1;
            done    <= 1'b1;
          end
        end
        S_REM: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          mul_sel <= SEL_IDLE;
          iter    <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_seq.sv
// tb/tb_goldschmidt_seq.sv - directed bench for goldschmidt_seq
// Per-cycle symbol strings (B=N+D, N, D, K, Q, R=rem, .=none) give the expected pulse order.
module tb_goldschmidt_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a;
  logic       start_b;
  logic [1:0] op;

  logic       a_busy, a_done, a_en_n, a_en_d, a_en_k, a_en_qd, a_rem;
  logic [1:0] a_sel;
  logic [3:0] a_iter;
  logic       b_busy, b_done, b_en_n, b_en_d, b_en_k, b_en_qd, b_rem;
  logic [1:0] b_sel;
  logic [3:0] b_iter;

  goldschmidt_seq dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .op(op),
    .busy(a_busy), .done(a_done), .enableN(a_en_n), .enableD(a_en_d),
    .enableK(a_en_k), .enableQD(a_en_qd), .rem(a_rem), .mul_sel(a_sel), .iter(a_iter)
  );

  goldschmidt_seq #(.N_ITER(2), .MUL_LAT(2)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .op(op),
    .busy(b_busy), .done(b_done), .enableN(b_en_n), .enableD(b_en_d),
    .enableK(b_en_k), .enableQD(b_en_qd), .rem(b_rem), .mul_sel(b_sel), .iter(b_iter)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic dsel     = 1'b0;

  logic       o_busy, o_done, o_en_n, o_en_d, o_en_k, o_en_qd, o_rem;
  logic [1:0] o_sel;
  logic [3:0] o_iter;

  always_comb begin
    o_busy  = dsel ? b_busy  : a_busy;
    o_done  = dsel ? b_done  : a_done;
    o_en_n  = dsel ? b_en_n  : a_en_n;
    o_en_d  = dsel ? b_en_d  : a_en_d;
    o_en_k  = dsel ? b_en_k  : a_en_k;
    o_en_qd = dsel ? b_en_qd : a_en_qd;
    o_rem   = dsel ? b_rem   : a_rem;
    o_sel   = dsel ? b_sel   : a_sel;
    o_iter  = dsel ? b_iter  : a_iter;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sym();
    logic [4:0] v;
    v = {o_en_n, o_en_d, o_en_k, o_en_qd, o_rem};
    case (v)
      5'b00000: return int'(".");
      5'b11000: return int'("B");
      5'b10000: return int'("N");
      5'b01000: return int'("D");
      5'b00100: return int'("K");
      5'b00010: return int'("Q");
      5'b00001: return int'("R");
      default:  return int'("?");
    endcase
  endfunction

  task automatic drive_start(input logic v);
    if (dsel) start_b = v;
    else      start_a = v;
  endtask

  // Cycle k is observed at the falling edge just before rising edge k after the start-sampling edge.
  task automatic run_op(input logic which, input logic [1:0] opv, input string nm,
                        input string es, input string ms, input string is,
                        input bit pre_started, input bit poke);
    int n_len;
    int dones;
    n_len = es.len();
    dones = 0;
    dsel  = which;
    if (!pre_started) begin
      @(negedge clk);
      op = opv;
      drive_start(1'b1);
    end
    @(posedge clk);
    #1;
    drive_start(1'b0);
    op = opv ^ 2'b01;
    for (int k = 1; k <= n_len; k++) begin
      @(negedge clk);
      check($sformatf("%s sym@%0d", nm, k), sym(), int'(es[k-1]));
      check($sformatf("%s mul_sel@%0d", nm, k), int'(o_sel), int'(ms[k-1]) - 48);
      check($sformatf("%s iter@%0d", nm, k), int'(o_iter), int'(is[k-1]) - 48);
      check($sformatf("%s busy@%0d", nm, k), int'(o_busy), 1);
      check($sformatf("%s done=rem@%0d", nm, k), int'(o_done), int'(o_rem));
      if (o_done) dones++;
      if (poke) begin
        drive_start((k == 3) || (k == 7) || (k == n_len));
        if (k == n_len) op = opv;
      end
    end
    @(negedge clk);
    check({nm, " busy after"}, int'(o_busy), 0);
    check({nm, " done after"}, int'(o_done), 0);
    check({nm, " iter after"}, int'(o_iter), 0);
    check({nm, " mul_sel after"}, int'(o_sel), 3);
    check({nm, " done count"}, dones, 1);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, " busy"}, int'(o_busy), 0);
    check({nm, " sym"}, sym(), int'("."));
    check({nm, " done"}, int'(o_done), 0);
    check({nm, " mul_sel"}, int'(o_sel), 3);
    check({nm, " iter"}, int'(o_iter), 0);
  endtask

  initial begin
    int n_busy;
    int n_done;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    op      = 2'b00;
    repeat (2) @(negedge clk);
    dsel = 1'b0;
    check_quiet("reset a");
    dsel = 1'b1;
    check_quiet("reset b");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(1'b0, 2'b00, "div", "BNDKNDKNDKQR", "301301301323", "000011122200", 1'b0, 1'b0);
    run_op(1'b0, 2'b01, "sqrt", "BNDDKNDDKNDDKQR", "301130113011323", "000001111222200", 1'b0, 1'b0);
    run_op(1'b1, 2'b00, "div_l2", "B.N.DK.N.DK.QR", "30011300113223", "00000011111000", 1'b0, 1'b0);

    run_op(1'b0, 2'b00, "div_poke", "BNDKNDKNDKQR", "301301301323", "000011122200", 1'b0, 1'b1);
    run_op(1'b0, 2'b00, "div_b2b", "BNDKNDKNDKQR", "301301301323", "000011122200", 1'b1, 1'b0);

    dsel = 1'b0;
    @(negedge clk);
    op      = 2'b00;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    check("abort pre sym", sym(), int'("D"));
    check("abort pre iter", int'(o_iter), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("abort in reset");
    check("abort enables", int'({o_en_n, o_en_d, o_en_k, o_en_qd, o_rem}), 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_busy = 0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) n_busy++;
      if (o_done || o_rem) n_done++;
    end
    check("abort busy cycles", n_busy, 0);
    check("abort done pulses", n_done, 0);
    run_op(1'b0, 2'b00, "div_after_abort", "BNDKNDKNDKQR", "301301301323", "000011122200", 1'b0, 1'b0);

    @(negedge clk);
    op      = 2'b10;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n_busy  = 0;
    n_done  = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) n_busy++;
      if (sym() != int'(".")) n_done++;
    end
    check("illegal busy cycles", n_busy, 0);
    check("illegal pulse cycles", n_done, 0);
    run_op(1'b0, 2'b00, "div_after_illegal", "BNDKNDKNDKQR", "301301301323", "000011122200", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/goldschmidt_seq.md
Name: goldschmidt_seq

Overview:
Sequencing controller for the shared-multiplier Goldschmidt divide/square-root datapath inside fpdiv. It accepts a start/op request and steps the datapath through the operand load, the N/D/K refinement iterations, the final Q×D product and the remainder/rounding step. It drives the register enables (enableN, enableD, enableK, enableQD), the multiplier operand select, and the rem strobe that marks completion of an operation.

Parameters:
N_ITER, 3, number of Goldschmidt refinement iterations (1..15)
MUL_LAT, 1, shared-multiplier latency in cycles (1..4); a product is valid in the last cycle of its MUL_LAT window

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled only in IDLE
op  input  2  00 = divide, 01 = sqrt, 1x = illegal; captured with start
busy  output  1  high from LOAD through REM inclusive
done  output  1  one-cycle pulse, coincident with rem
enableN  output  1  load the N register (initial load or N×K product)
enableD  output  1  load the D register (initial load or D×K product)
enableK  output  1  load K = 2 − D (div) or (3 − D)/2 (sqrt)
enableQD  output  1  load the QD register from the Q×D product
rem  output  1  high for the one REM cycle; the datapath applies remainder-sign rounding
mul_sel  output  2  multiplier operands: 00 N×K, 01 D×K, 10 Q×D, 11 idle
iter  output  4  current iteration index, 0-based; 0 outside iterations

Behaviour:
- Reset (reset=0, takes effect immediately and asynchronously): state=IDLE. All enables, rem, done and busy are 0. mul_sel=11. iter=0. Internal counters clear.
- While reset is held, nothing is accepted. An operation in flight is abandoned: no enable, rem or done pulse is issued for it.
- States: IDLE, LOAD, MULN, MULD, MULD2 (sqrt only), CALCK, QD, REM.
- IDLE: a start edge with op=00 or 01 latches op and moves to LOAD.
- IDLE: start with op=1x is dropped. No busy, no pulses.
- IDLE: start is ignored in every other state, including REM.
- LOAD (1 cycle): enableN=enableD=1 to capture the initial operands. Then go to MULN with iter=0.
- MULN (MUL_LAT cycles): mul_sel=00. enableN=1 in the last cycle only.
- MULD (MUL_LAT cycles): mul_sel=01. enableD=1 in the last cycle only.
- MULD2 (sqrt only, MUL_LAT cycles): mul_sel=01. enableD=1 in the last cycle only.
- CALCK (1 cycle): enableK=1.
- After CALCK: if iter==N_ITER−1, go to QD; otherwise increment iter and go to MULN.
- QD (MUL_LAT cycles): mul_sel=10. enableQD=1 in the last cycle. iter clears to 0 on entry.
- REM (1 cycle): rem=1 and done=1. Then go to IDLE.
- A latency counter counts down the MUL_LAT window and reloads on entry to each MUL* or QD state.
- At most one enable is high in any cycle, except enableN+enableD together in LOAD.
- Latency is counted from the edge that samples start to the edge at which done is high:
  - divide: 2 + N_ITER·(2·MUL_LAT+1) + MUL_LAT
  - sqrt: 2 + N_ITER·(3·MUL_LAT+1) + MUL_LAT
  - defaults give 12 (divide) and 15 (sqrt).
- Earliest restart: start in the first IDLE cycle after REM. The back-to-back period is latency+1 cycles.
- rem falls when the state leaves REM. That falling edge is the point at which the quotient output is stable.
- op is held internally for the whole operation. Changes on the op port after start have no effect.

Test Plan:
- Divide, defaults: op=00, one-cycle start → busy rises next cycle. Pulse order LOAD(N+D), then 3×(N, D, K), then QD, then rem+done. done is high on the 12th edge after start. Exactly one done. Then busy=0 and iter=0.
- Sqrt, defaults: op=01 → per-iteration order N, D, D, K. done on the 15th edge. mul_sel sequence per iteration is 00, 01, 01, idle.
- MUL_LAT=2, N_ITER=2, divide → each enable fires only in the second cycle of its window, with mul_sel held both cycles. done on edge 2+2·5+2=14.
- start pulsed at cycles 3, 7 and in the REM cycle of a running divide → ignored, single done. start in the next IDLE cycle is accepted, giving a 13-cycle period.
- reset driven low mid-MULD of iteration 1 (asynchronously, between edges) → all outputs 0 immediately and mul_sel=11. After release, no done appears. A new start completes normally in 12 cycles.
- op=10 with start in IDLE → busy stays 0 and no pulses for 20 cycles. A following op=00 start completes normally.
